// File: rtl/bypass_scoreboard_if.sv
// ID-stage bundle between the pipeline and the bypass scoreboard.
// Valid semantics: id_valid qualifies the ID fields; stall/md_busy are the only back-pressure.
interface bypass_scoreboard_if #(
    parameter int NRD = 2,
    parameter int DW  = 32
);
    logic                id_valid;
    logic [NRD-1:0]      id_use;
    logic [NRD*5-1:0]    id_rs;
    logic [NRD*DW-1:0]   id_rfout;
    logic                id_wr_en;
    logic [4:0]          id_wr_reg;
    logic [1:0]          id_regsrc;
    logic [DW-1:0]       id_pc;
    logic                flush;
    logic [DW-1:0]       ex_alu_result;
    logic [DW-1:0]       mem_rdata;
    logic [DW-1:0]       md_result;
    logic [NRD*DW-1:0]   id_fwd_data;
    logic                stall;
    logic                md_busy;

    modport master (
        output id_valid, id_use, id_rs, id_rfout, id_wr_en, id_wr_reg,
               id_regsrc, id_pc, flush, ex_alu_result, mem_rdata, md_result,
        input  id_fwd_data, stall, md_busy
    );

    modport slave (
        input  id_valid, id_use, id_rs, id_rfout, id_wr_en, id_wr_reg,
               id_regsrc, id_pc, flush, ex_alu_result, mem_rdata, md_result,
        output id_fwd_data, stall, md_busy
    );
endinterface

// File: rtl/bypass_scoreboard.sv
// Tracks in-flight register writers (EX..WB) and forwards/stalls ID operands.
// Entry 0 is EX; a multiply/divide parks in EX and freezes the tracker.
module bypass_scoreboard #(
    parameter int NRD    = 2,
    parameter int DEPTH  = 3,
    parameter int DW     = 32,
    parameter int MD_LAT = 4
) (
    input logic               clk,
    input logic               rstn,
    bypass_scoreboard_if.slave sb
);
    localparam int CW = $clog2(MD_LAT + 1);

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_DMEM = 2'b01;
    localparam logic [1:0] SRC_PC4  = 2'b10;
    localparam logic [1:0] SRC_MD   = 2'b11;

    logic          valid_q [DEPTH];
    logic [4:0]    dest_q  [DEPTH];
    logic [1:0]    src_q   [DEPTH];
    logic          rdy_q   [DEPTH];
    logic [DW-1:0] val_q   [DEPTH];
    logic [CW-1:0] md_cnt_q;

    logic          valid_d [DEPTH];
    logic [4:0]    dest_d  [DEPTH];
    logic [1:0]    src_d   [DEPTH];
    logic          rdy_d   [DEPTH];
    logic [DW-1:0] val_d   [DEPTH];
    logic [CW-1:0] md_cnt_d;

    logic [NRD-1:0] hit;
    logic [NRD-1:0] hit_rdy;
    logic [DW-1:0]  hit_val [NRD];
    logic [NRD-1:0] port_stall;
    logic           md_busy;
    logic           stall;
    logic           ins;

    // Lookup sees registered state only; the loop runs oldest-to-youngest
    // so the youngest matching producer overrides older ones.
    always_comb begin
        for (int k = 0; k < NRD; k++) begin
            hit[k]     = 1'b0;
            hit_rdy[k] = 1'b0;
            hit_val[k] = '0;
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (valid_q[i] && (dest_q[i] != 5'd0) &&
                    (dest_q[i] == sb.id_rs[k*5 +: 5])) begin
                    hit[k]     = 1'b1;
                    hit_rdy[k] = rdy_q[i];
                    hit_val[k] = val_q[i];
                end
            end
            port_stall[k] = sb.id_use[k] & hit[k] & ~hit_rdy[k];
        end
    end

    always_comb begin
        sb.id_fwd_data = sb.id_rfout;
        for (int k = 0; k < NRD; k++) begin
            if (hit[k] && sb.id_use[k]) begin
                sb.id_fwd_data[k*DW +: DW] = hit_val[k];
            end
        end
    end

    assign md_busy    = valid_q[0] && (src_q[0] == SRC_MD) && (md_cnt_q != '0);
    assign stall      = md_busy | (sb.id_valid & (|port_stall));
    assign sb.md_busy = md_busy;
    assign sb.stall   = stall;

    assign ins = sb.id_valid & sb.id_wr_en & ~stall & ~sb.flush &
                 (sb.id_wr_reg != 5'd0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i];
            dest_d[i]  = dest_q[i];
            src_d[i]   = src_q[i];
            rdy_d[i]   = rdy_q[i];
            val_d[i]   = val_q[i];
        end
        md_cnt_d = md_cnt_q;

        if (md_busy) begin
            // Frozen: only the EX-resident mul/div counts down and captures.
            md_cnt_d = md_cnt_q - CW'(1);
            if (md_cnt_q == CW'(1)) begin
                val_d[0] = sb.md_result;
                rdy_d[0] = 1'b1;
            end
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                valid_d[i] = valid_q[i-1];
                dest_d[i]  = dest_q[i-1];
                src_d[i]   = src_q[i-1];
                rdy_d[i]   = rdy_q[i-1];
                val_d[i]   = val_q[i-1];
            end
            if (valid_q[0] && (src_q[0] == SRC_ALU)) begin
                val_d[1] = sb.ex_alu_result;
                rdy_d[1] = 1'b1;
            end
            if (valid_q[1] && (src_q[1] == SRC_DMEM)) begin
                val_d[2] = sb.mem_rdata;
                rdy_d[2] = 1'b1;
            end

            valid_d[0] = ins;
            dest_d[0]  = ins ? sb.id_wr_reg : 5'd0;
            src_d[0]   = ins ? sb.id_regsrc : 2'b00;
            rdy_d[0]   = ins && (sb.id_regsrc == SRC_PC4);
            val_d[0]   = (ins && (sb.id_regsrc == SRC_PC4)) ? (sb.id_pc + DW'(4)) : '0;
            md_cnt_d   = (ins && (sb.id_regsrc == SRC_MD)) ? CW'(MD_LAT) : '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                dest_q[i]  <= 5'd0;
                src_q[i]   <= 2'b00;
                rdy_q[i]   <= 1'b0;
                val_q[i]   <= '0;
            end
            md_cnt_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= valid_d[i];
                dest_q[i]  <= dest_d[i];
                src_q[i]   <= src_d[i];
                rdy_q[i]   <= rdy_d[i];
                val_q[i]   <= val_d[i];
            end
            md_cnt_q <= md_cnt_d;
        end
    end
endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: driver pushes expected {stall, md_busy, fwd1, fwd0}
// into a queue each cycle; a negedge monitor pops and compares under a care mask.
module tb_bypass_scoreboard;
    localparam int W = 66;
    localparam logic [1:0] ALU  = 2'b00;
    localparam logic [1:0] DMEM = 2'b01;
    localparam logic [1:0] PC4  = 2'b10;
    localparam logic [1:0] MD   = 2'b11;
    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_1111;
    localparam logic [W-1:0] M_ALL   = {W{1'b1}};
    localparam logic [W-1:0] M_CTL   = {2'b11, 64'h0};
    localparam logic [W-1:0] M_NO_F0 = {2'b11, 32'hFFFF_FFFF, 32'h0};

    logic clk;
    logic rstn;

    bypass_scoreboard_if #(.NRD(2), .DW(32)) sb_if ();

    bypass_scoreboard #(.NRD(2), .DEPTH(3), .DW(32), .MD_LAT(4)) dut (
        .clk  (clk),
        .rstn (rstn),
        .sb   (sb_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [W-1:0] exp_q  [$];
    logic [W-1:0] mask_q [$];
    string        tag_q  [$];
    int n_checks = 0;
    int n_fail   = 0;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            logic [W-1:0] e;
            logic [W-1:0] m;
            logic [W-1:0] got;
            string        t;
            e = exp_q.pop_front();
            m = mask_q.pop_front();
            t = tag_q.pop_front();
            got = {sb_if.stall, sb_if.md_busy, sb_if.id_fwd_data};
            n_checks++;
            if ((got & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL %s got=%h exp=%h mask=%h", t, got, e, m);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.id_valid  = 1'b0;
        sb_if.id_use    = 2'b00;
        sb_if.id_rs     = 10'd0;
        sb_if.id_wr_en  = 1'b0;
        sb_if.id_wr_reg = 5'd0;
        sb_if.id_regsrc = 2'b00;
        sb_if.id_pc     = 32'd0;
        sb_if.flush     = 1'b0;
    endtask

    task automatic ins(input logic [4:0] r, input logic [1:0] src, input logic [31:0] pc);
        sb_if.id_valid  = 1'b1;
        sb_if.id_wr_en  = 1'b1;
        sb_if.id_wr_reg = r;
        sb_if.id_regsrc = src;
        sb_if.id_pc     = pc;
    endtask

    task automatic rd(input logic [1:0] u, input logic [4:0] r0, input logic [4:0] r1);
        sb_if.id_valid = 1'b1;
        sb_if.id_use   = u;
        sb_if.id_rs    = {r1, r0};
    endtask

    task automatic expect_out(input string t, input logic st, input logic bz,
                              input logic [31:0] f1, input logic [31:0] f0,
                              input logic [W-1:0] m);
        exp_q.push_back({st, bz, f1, f0});
        mask_q.push_back(m);
        tag_q.push_back(t);
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            step();
            idle();
        end
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        sb_if.id_rfout      = {RF1, RF0};
        sb_if.ex_alu_result = 32'd0;
        sb_if.mem_rdata     = 32'd0;
        sb_if.md_result     = 32'd0;

        // Reset: no forwarding, no stall even with live reads.
        step(); rd(2'b11, 5'd31, 5'd3);
        expect_out("reset", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); rstn = 1'b1; idle();
        step();

        // PC+4 producer forwarded through EX, MEM, WB, then gone.
        idle(); ins(5'd31, PC4, 32'h3000);
        expect_out("jal_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); rd(2'b01, 5'd31, 5'd31);
        expect_out("jr_fwd", 1'b0, 1'b0, RF1, 32'h3004, M_ALL);
        step(); idle(); rd(2'b11, 5'd31, 5'd31);
        expect_out("jr_mem", 1'b0, 1'b0, 32'h3004, 32'h3004, M_ALL);
        step(); idle(); rd(2'b11, 5'd31, 5'd31);
        expect_out("jr_wb", 1'b0, 1'b0, 32'h3004, 32'h3004, M_ALL);
        step(); idle(); rd(2'b11, 5'd31, 5'd31);
        expect_out("jr_gone", 1'b0, 1'b0, RF1, RF0, M_ALL);

        // ALU producer: one stall cycle, then captured value.
        step(); idle(); ins(5'd8, ALU, 32'd0); sb_if.ex_alu_result = 32'h11;
        expect_out("alu_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); rd(2'b11, 5'd8, 5'd9); sb_if.ex_alu_result = 32'h55;
        expect_out("beq_stall", 1'b1, 1'b0, RF1, 32'h0, M_NO_F0);
        step(); idle(); rd(2'b11, 5'd8, 5'd9); sb_if.ex_alu_result = 32'h66;
        expect_out("beq_fwd", 1'b0, 1'b0, RF1, 32'h55, M_ALL);
        drain(3);

        // Load producer: two stall cycles; $0 never forwarded.
        step(); idle(); ins(5'd4, DMEM, 32'd0);
        expect_out("lw_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); rd(2'b11, 5'd4, 5'd0);
        expect_out("bne_stall1", 1'b1, 1'b0, RF1, 32'h0, M_NO_F0);
        step(); idle(); rd(2'b11, 5'd4, 5'd0); sb_if.mem_rdata = 32'hDEAD;
        expect_out("bne_stall2", 1'b1, 1'b0, RF1, 32'h0, M_NO_F0);
        step(); idle(); rd(2'b11, 5'd4, 5'd0); sb_if.mem_rdata = 32'h0;
        expect_out("bne_fwd", 1'b0, 1'b0, RF1, 32'hDEAD, M_ALL);
        drain(3);

        // Flushed writer must not be tracked.
        step(); idle(); ins(5'd9, ALU, 32'd0); sb_if.flush = 1'b1;
        expect_out("flush_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); rd(2'b01, 5'd9, 5'd9);
        expect_out("flush_none", 1'b0, 1'b0, RF1, RF0, M_ALL);
        drain(2);

        // Mul/div: 4 busy cycles, older $7 frozen in MEM, then 0x10 forwarded.
        step(); idle(); ins(5'd7, ALU, 32'd0); sb_if.ex_alu_result = 32'h77;
        expect_out("alu7_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); ins(5'd2, MD, 32'd0); sb_if.md_result = 32'h10;
        expect_out("md_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        for (int c = 0; c < 4; c++) begin
            step(); idle(); rd(2'b11, 5'd2, 5'd7); sb_if.ex_alu_result = 32'h0;
            expect_out($sformatf("md_busy%0d", c), 1'b1, 1'b1, 32'h77, 32'h0, M_NO_F0);
        end
        step(); idle(); rd(2'b11, 5'd2, 5'd7);
        expect_out("md_done", 1'b0, 1'b0, 32'h77, 32'h10, M_ALL);
        drain(3);

        // Two writers of $5: PC+4 wraps to 0x1, younger ALU wins.
        step(); idle(); ins(5'd5, PC4, 32'hFFFF_FFFD);
        expect_out("pc4_wrap_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); ins(5'd5, ALU, 32'd0); sb_if.id_use = 2'b10; sb_if.id_rs = {5'd5, 5'd0};
        expect_out("old5_ready", 1'b0, 1'b0, 32'h1, RF0, M_ALL);
        step(); idle(); rd(2'b11, 5'd5, 5'd5); sb_if.ex_alu_result = 32'h99;
        expect_out("young5_stall", 1'b1, 1'b0, 32'h0, 32'h0, M_CTL);
        step(); idle(); rd(2'b11, 5'd5, 5'd5); sb_if.ex_alu_result = 32'h0;
        expect_out("young5_fwd", 1'b0, 1'b0, 32'h99, 32'h99, M_ALL);
        drain(3);

        // Reset during mul/div busy aborts tracking; same-cycle insert not seen.
        step(); idle(); ins(5'd3, MD, 32'd0);
        expect_out("md3_ins", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); rd(2'b11, 5'd3, 5'd3);
        expect_out("md3_busy", 1'b1, 1'b1, 32'h0, 32'h0, M_CTL);
        step(); idle(); rd(2'b11, 5'd3, 5'd3); rstn = 1'b0;
        expect_out("rst_mid_md", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); rstn = 1'b1; idle(); ins(5'd3, PC4, 32'h100); rd(2'b11, 5'd3, 5'd3);
        expect_out("post_rst_empty", 1'b0, 1'b0, RF1, RF0, M_ALL);
        step(); idle(); rd(2'b11, 5'd3, 5'd3);
        expect_out("post_rst_fwd", 1'b0, 1'b0, 32'h104, 32'h104, M_ALL);

        drain(3);
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bypass_scoreboard.md
BYPASS_SCOREBOARD -- requirements
Module: bypass_scoreboard

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- NRD, 2, number of ID read ports.
- DEPTH, 3, tracked producer stages, with entry 0 = EX, 1 = MEM, DEPTH-1 = WB; minimum 3.
- DW, 32, data width.
- MD_LAT, 4, multiply/divide cycles held in EX; minimum 1.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock.
- rstn, in, 1, asynchronous active-low reset.
- id_valid, in, 1, ID holds a real instruction.
- id_use, in, NRD, port k value consumed at ID (branch / jump-register).
- id_rs, in, NRD*5, source register per port.
- id_rfout, in, NRD*DW, raw register-file data per port.
- id_wr_en, in, 1, ID instruction writes a register.
- id_wr_reg, in, 5, its destination register.
- id_regsrc, in, 2, 00 ALU, 01 DMEM, 10 PCPLUS4, 11 MULDIV.
- id_pc, in, DW, ID instruction PC.
- flush, in, 1, kill the ID instruction.
- ex_alu_result, in, DW, ALU result of entry 0.
- mem_rdata, in, DW, load data of entry 1.
- md_result, in, DW, mul/div result.
- id_fwd_data, out, NRD*DW, corrected operand per port.
- stall, out, 1, hold PC and ID.
- md_busy, out, 1, mul/div occupying EX; freeze the whole pipeline.

Function
REQ-003 Each entry SHALL hold valid, dest[4:0], src[1:0], rdy, val[DW-1:0].
REQ-004 Port k lookup SHALL select the lowest-index valid entry with dest == id_rs[k] and dest != 0; that entry is the youngest producer.
REQ-005 id_fwd_data[k] SHALL be that entry's val when one exists and id_use[k]=1; otherwise id_rfout[k]. The output is combinational in the same cycle.
REQ-006 stall SHALL be 1 when md_busy=1.
REQ-007 stall SHALL also be 1 when id_valid=1 and any port with id_use[k]=1 matches an entry whose rdy=0.
REQ-008 When md_busy=1, all entries SHALL hold their contents and no insert SHALL occur.
REQ-009 When md_busy=0, every clock edge SHALL shift entry i to entry i+1; entry DEPTH-1 is discarded.
REQ-010 On that shift, entry 0 SHALL load the ID instruction when id_valid & id_wr_en & !stall & !flush & id_wr_reg != 0; otherwise entry 0 SHALL load a bubble with valid=0.
REQ-011 Insert with src PCPLUS4 SHALL set rdy=1 and val=id_pc+4, modulo 2^DW. Insert with src ALU, DMEM or MULDIV SHALL set rdy=0.
REQ-012 On the 0->1 shift, an entry with src ALU SHALL capture val=ex_alu_result and set rdy=1.
REQ-013 On the 1->2 shift, an entry with src DMEM SHALL capture val=mem_rdata and set rdy=1.
REQ-014 MULDIV insert SHALL load md_cnt=MD_LAT.
REQ-015 md_busy SHALL equal (entry0 valid & src MULDIV & md_cnt != 0).
REQ-016 While md_busy=1, md_cnt SHALL decrement by 1 per cycle. At md_cnt=1, entry 0 SHALL capture val=md_result and set rdy=1.
REQ-017 A MULDIV instruction therefore SHALL occupy EX for MD_LAT+1 cycles including its shift-in cycle.
REQ-018 Simultaneous events:
- flush with stall: no insert, bubble shifted.
- flush with md_busy: freeze takes priority; flush only suppresses insertion.
- id_rs=0: never forwarded, never stalls.
- Two entries match: the youngest wins even if older ones are ready.
REQ-019 Lookup SHALL use the current registered state only, never the value being inserted this cycle.

Reset
REQ-020 While rstn=0, asynchronously:
- all entry valid, rdy, dest, src and val SHALL clear to 0;
- md_cnt SHALL be 0;
- md_busy SHALL be 0;
- stall SHALL be 0;
- id_fwd_data SHALL equal id_rfout.
REQ-021 Reset asserted mid-MULDIV or mid-stall SHALL abort all tracking. The first cycle after release SHALL behave as an empty scoreboard.

Verification
REQ-022 Scenario: insert jal-style PCPLUS4 to $31 with id_pc=0x3000; next cycle jr $31 with id_use[0]=1 -> stall=0, id_fwd_data[0]=0x3004.
REQ-023 Scenario: ALU writes $8, then beq $8,$9 next cycle -> stall=1 for one cycle; after the shift ex_alu_result=0x55 is forwarded and port 0 reads 0x55 with stall=0.
REQ-024 Scenario: lw $4, then bne $4,$0 -> stall=1 for two cycles; then id_fwd_data[0]=mem_rdata value 0xDEAD.
REQ-025 Scenario: MULDIV to $2 with MD_LAT=4, md_result=0x10 -> md_busy=1 for 4 cycles, entries frozen; then jr $2 forwards 0x10.
REQ-026 Scenario: two writers to $5 (older ready 0x1, younger ALU not ready) -> stall=1; after the younger's capture, forward the younger value, not 0x1.
REQ-027 Scenario: rstn pulsed low during md_busy=1 -> md_busy=0 and stall=0 asynchronously; id_fwd_data equals id_rfout afterwards.
